// File: rtl/siphash_axil_pkg.sv
// Shared definitions for the SipHash AXI4-Lite register block: register offsets,
// CTRL/STATUS bit positions, response codes and the channel FSM state types.
package siphash_axil_pkg;

   localparam logic [5:0] OFF_CTRL    = 6'h00;
   localparam logic [5:0] OFF_STATUS  = 6'h04;
   localparam logic [5:0] OFF_KEY0    = 6'h08;
   localparam logic [5:0] OFF_KEY1    = 6'h0C;
   localparam logic [5:0] OFF_KEY2    = 6'h10;
   localparam logic [5:0] OFF_KEY3    = 6'h14;
   localparam logic [5:0] OFF_MSG_LO  = 6'h18;
   localparam logic [5:0] OFF_MSG_HI  = 6'h1C;
   localparam logic [5:0] OFF_HASH_LO = 6'h20;
   localparam logic [5:0] OFF_HASH_HI = 6'h24;

   localparam int CTRL_START_BIT  = 0;
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   // KEY0..KEY3, MSG_LO, MSG_HI occupy consecutive words starting at OFF_KEY0
   localparam int NUM_RW_REGS = 6;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   function automatic logic [5:0] word_off(input logic [5:0] addr);
      return {addr[5:2], 2'b00};
   endfunction

endpackage

// File: rtl/siphash_axil_reg32.sv
// Byte-strobed 32-bit register with asynchronous active-low reset.
module siphash_axil_reg32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [3:0]  strb,
   input  logic [31:0] d,
   output logic [31:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) q[8*b +: 8] <= d[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/siphash_axil_regs.sv
// AXI4-Lite register front end for a SipHash core (key, message, control, status, hash).
// Define SIPHASH_AXIL_SLVERR_EN to answer unmapped/read-only accesses with SLVERR.
module siphash_axil_regs
   import siphash_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
   input  logic [2:0]                      AWPROT,
   input  logic                            AWVALID,
   output logic                            AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
   input  logic                            WVALID,
   output logic                            WREADY,
   output logic [1:0]                      BRESP,
   output logic                            BVALID,
   input  logic                            BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
   input  logic [2:0]                      ARPROT,
   input  logic                            ARVALID,
   output logic                            ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]                      RRESP,
   output logic                            RVALID,
   input  logic                            RREADY,
   output logic [127:0]                    key_o,
   output logic [63:0]                     msg_o,
   output logic                            start_o,
   input  logic                            busy_i,
   input  logic                            done_i,
   input  logic [63:0]                     hash_i
);

   wr_state_t   wr_state;
   rd_state_t   rd_state;
   logic [31:0] rw_q [NUM_RW_REGS];
   logic [63:0] hash_q;
   logic        done_q;
   logic [5:0]  wr_off;
   logic [5:0]  rd_off;
   logic        wr_fire;
   logic        rd_fire;
   logic        start_fire;
   logic        done_clr;
   logic [1:0]  wr_resp;
   logic [1:0]  rd_resp;
   logic [31:0] rd_data;
   logic        unused_ok;

   assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

   assign wr_off     = word_off(AWADDR[5:0]);
   assign rd_off     = word_off(ARADDR[5:0]);
   assign wr_fire    = (wr_state == W_IDLE) && AWREADY && WREADY && AWVALID && WVALID;
   assign rd_fire    = (rd_state == R_IDLE) && ARREADY && ARVALID;
   assign start_fire = wr_fire && (wr_off == OFF_CTRL) && WSTRB[0] && WDATA[CTRL_START_BIT] && !busy_i;
   assign done_clr   = start_fire ||
                       (wr_fire && (wr_off == OFF_STATUS) && WSTRB[0] && WDATA[STATUS_DONE_BIT]);

`ifdef SIPHASH_AXIL_SLVERR_EN
   assign wr_resp = (wr_off inside {OFF_CTRL, OFF_STATUS, OFF_KEY0, OFF_KEY1, OFF_KEY2,
                                    OFF_KEY3, OFF_MSG_LO, OFF_MSG_HI}) ? RESP_OKAY : RESP_SLVERR;
   assign rd_resp = (rd_off inside {OFF_CTRL, OFF_STATUS, OFF_KEY0, OFF_KEY1, OFF_KEY2, OFF_KEY3,
                                    OFF_MSG_LO, OFF_MSG_HI, OFF_HASH_LO, OFF_HASH_HI})
                    ? RESP_OKAY : RESP_SLVERR;
`else
   assign wr_resp = RESP_OKAY;
   assign rd_resp = RESP_OKAY;
`endif

   for (genvar i = 0; i < NUM_RW_REGS; i++) begin : g_rw
      siphash_axil_reg32 u_reg (
         .clk   (ACLK),
         .rst_n (ARESETN),
         .we    (wr_fire && (wr_off == OFF_KEY0 + 6'(4 * i))),
         .strb  (WSTRB),
         .d     (WDATA),
         .q     (rw_q[i])
      );
   end

   assign key_o = {rw_q[3], rw_q[2], rw_q[1], rw_q[0]};
   assign msg_o = {rw_q[5], rw_q[4]};

   // CTRL and unmapped words read as zero
   always_comb begin
      rd_data = '0;
      case (rd_off)
         OFF_STATUS: begin
            rd_data[STATUS_BUSY_BIT] = busy_i;
            rd_data[STATUS_DONE_BIT] = done_q;
         end
         OFF_KEY0:    rd_data = rw_q[0];
         OFF_KEY1:    rd_data = rw_q[1];
         OFF_KEY2:    rd_data = rw_q[2];
         OFF_KEY3:    rd_data = rw_q[3];
         OFF_MSG_LO:  rd_data = rw_q[4];
         OFF_MSG_HI:  rd_data = rw_q[5];
         OFF_HASH_LO: rd_data = hash_q[31:0];
         OFF_HASH_HI: rd_data = hash_q[63:32];
         default:     rd_data = '0;
      endcase
   end

   // A same-edge done_i beats any clear of DONE
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         start_o <= 1'b0;
         done_q  <= 1'b0;
         hash_q  <= '0;
      end else begin
         start_o <= start_fire;
         if (done_i)        done_q <= 1'b1;
         else if (done_clr) done_q <= 1'b0;
         if (done_i) hash_q <= hash_i;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state <= W_IDLE;
         AWREADY  <= 1'b0;
         WREADY   <= 1'b0;
         BVALID   <= 1'b0;
         BRESP    <= RESP_OKAY;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (wr_fire) begin
                  AWREADY  <= 1'b0;
                  WREADY   <= 1'b0;
                  BVALID   <= 1'b1;
                  BRESP    <= wr_resp;
                  wr_state <= W_RESP;
               end else begin
                  AWREADY <= AWVALID && WVALID;
                  WREADY  <= AWVALID && WVALID;
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  BVALID   <= 1'b0;
                  BRESP    <= RESP_OKAY;
                  wr_state <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // Read data is registered on the address handshake, so it reflects pre-write state
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rd_state <= R_IDLE;
         ARREADY  <= 1'b0;
         RVALID   <= 1'b0;
         RRESP    <= RESP_OKAY;
         RDATA    <= '0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (rd_fire) begin
                  ARREADY  <= 1'b0;
                  RVALID   <= 1'b1;
                  RRESP    <= rd_resp;
                  RDATA    <= (rd_resp == RESP_OKAY) ? rd_data : '0;
                  rd_state <= R_DATA;
               end else begin
                  ARREADY <= ARVALID;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  RVALID   <= 1'b0;
                  RRESP    <= RESP_OKAY;
                  rd_state <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_siphash_axil_regs.sv
// Scoreboard bench for siphash_axil_regs: expected responses are queued when a
// transaction is issued and compared when the DUT answers.
module tb_siphash_axil_regs;
   import siphash_axil_pkg::*;

`ifdef SIPHASH_AXIL_SLVERR_EN
   localparam logic [1:0] ERR = 2'b10;
`else
   localparam logic [1:0] ERR = 2'b00;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [5:0]   AWADDR, ARADDR;
   logic [2:0]   AWPROT, ARPROT;
   logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic         ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0]  WDATA, RDATA;
   logic [3:0]   WSTRB;
   logic [1:0]   BRESP, RRESP;
   logic [127:0] key_o;
   logic [63:0]  msg_o, hash_i;
   logic         start_o, busy_i, done_i;

   int           n_cmp = 0;
   int           n_bad = 0;
   int           start_cnt = 0;
   int           s0;
   logic [1:0]   wr_q[$];
   logic [33:0]  rd_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) if (start_o === 1'b1) start_cnt <= start_cnt + 1;

   siphash_axil_regs dut (
      .ACLK(clk), .ARESETN(rst_n),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .key_o(key_o), .msg_o(msg_o), .start_o(start_o),
      .busy_i(busy_i), .done_i(done_i), .hash_i(hash_i)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input int bdelay, input bit with_done);
      int n = 0;
      wr_q.push_back(exp_resp);
      AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
      while (!(AWREADY && WREADY) && n < 20) begin tick(); n++; end
      if (!(AWREADY && WREADY)) begin
         check("aw_w_ready_timeout", {AWREADY, WREADY}, 2'b11);
         AWVALID = 1'b0; WVALID = 1'b0;
         void'(wr_q.pop_front());
         return;
      end
      if (with_done) done_i = 1'b1;
      tick();
      done_i = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
      check("ready_one_cycle", {AWREADY, WREADY}, 2'b00);
      check("bvalid_after_accept", BVALID, 1'b1);
      for (int i = 0; i < bdelay; i++) begin
         tick();
         check("bvalid_hold", {BVALID, BRESP}, {1'b1, exp_resp});
      end
      check($sformatf("bresp@%0h", addr), BRESP, wr_q.pop_front());
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      check("bvalid_clear", BVALID, 1'b0);
   endtask

   task automatic axi_read(input logic [5:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
      int n = 0;
      rd_q.push_back({exp_resp, exp_data});
      ARADDR = addr; ARVALID = 1'b1;
      while (!ARREADY && n < 20) begin tick(); n++; end
      if (!ARREADY) begin
         check("arready_timeout", ARREADY, 1'b1);
         ARVALID = 1'b0;
         void'(rd_q.pop_front());
         return;
      end
      tick();
      ARVALID = 1'b0;
      check("rvalid_after_accept", RVALID, 1'b1);
      check($sformatf("rd@%0h", addr), {RRESP, RDATA}, rd_q.pop_front());
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
      check("rvalid_clear", RVALID, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0; WDATA = '0; WSTRB = '0;
      AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
      busy_i = 0; done_i = 0; hash_i = '0;
      repeat (3) tick();
      check("rst_handshake", {AWREADY, WREADY, BVALID, ARREADY, RVALID, start_o}, 6'b0);
      check("rst_resp_rdata", {BRESP, RRESP, RDATA}, 36'h0);
      check("rst_key_msg", {key_o[63:0] | key_o[127:64] | msg_o}, 64'h0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) begin
         logic [31:0] kw;
         kw = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
         axi_write(OFF_KEY0 + 6'(4*i), kw, 4'hF, RESP_OKAY, 0, 1'b0);
      end
      check("key_o", key_o, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      for (int i = 0; i < 4; i++) begin
         axi_read(OFF_KEY0 + 6'(4*i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, RESP_OKAY);
      end
      axi_read(OFF_STATUS, 32'h0, RESP_OKAY);

      fork
         axi_write(OFF_KEY0, 32'hDEADBEEF, 4'hF, RESP_OKAY, 0, 1'b0);
         axi_read(OFF_KEY0, 32'h03020100, RESP_OKAY);
      join
      axi_read(OFF_KEY0, 32'hDEADBEEF, RESP_OKAY);

      WVALID = 1'b1; WDATA = 32'h55667788; WSTRB = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_ready_w_only", {AWREADY, WREADY}, 2'b00);
      end
      axi_write(OFF_MSG_HI, 32'h55667788, 4'hF, RESP_OKAY, 4, 1'b0);

      axi_write(OFF_MSG_LO, 32'h00000000, 4'hF, RESP_OKAY, 0, 1'b0);
      axi_write(OFF_MSG_LO, 32'hFFFFFFFF, 4'b0101, RESP_OKAY, 0, 1'b0);
      axi_read(OFF_MSG_LO, 32'h00FF00FF, RESP_OKAY);
      check("msg_o", msg_o, 64'h55667788_00FF00FF);

      s0 = start_cnt;
      axi_write(OFF_CTRL, 32'h1, 4'hF, RESP_OKAY, 0, 1'b0);
      repeat (2) tick();
      check("start_pulse_cycles", start_cnt - s0, 1);
      axi_read(OFF_CTRL, 32'h0, RESP_OKAY);

      hash_i = 64'hA129CA61_49BE45E5;
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      axi_read(OFF_STATUS, 32'h2, RESP_OKAY);
      axi_read(OFF_HASH_LO, 32'h49BE45E5, RESP_OKAY);
      axi_read(OFF_HASH_HI, 32'hA129CA61, RESP_OKAY);
      axi_write(OFF_STATUS, 32'h2, 4'hF, RESP_OKAY, 0, 1'b0);
      axi_read(OFF_STATUS, 32'h0, RESP_OKAY);

      axi_write(OFF_STATUS, 32'h2, 4'hF, RESP_OKAY, 0, 1'b1);
      axi_read(OFF_STATUS, 32'h2, RESP_OKAY);

      busy_i = 1'b1;
      s0 = start_cnt;
      axi_write(OFF_CTRL, 32'h1, 4'hF, RESP_OKAY, 0, 1'b0);
      repeat (2) tick();
      check("start_while_busy", start_cnt - s0, 0);
      axi_read(OFF_STATUS, 32'h3, RESP_OKAY);
      busy_i = 1'b0;

      axi_write(OFF_HASH_LO, 32'h12345678, 4'hF, ERR, 0, 1'b0);
      axi_read(6'h3C, 32'h0, ERR);
      axi_read(OFF_HASH_LO, 32'h49BE45E5, RESP_OKAY);

      AWADDR = OFF_KEY1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      tick();
      rst_n = 1'b0;
      #1;
      check("rst_mid_ready", {AWREADY, WREADY, BVALID}, 3'b000);
      AWVALID = 1'b0; WVALID = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("rst_mid_no_bvalid", BVALID, 1'b0);
      check("rst_mid_key", key_o, 128'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
